iccm_boot_loader: RTL and testbench
===================================

# iccm_boot_loader

Framed boot-image loader that sits between the byte receivers (UART programmer or SPI slave) and the instruction memory. It parses a length-prefixed byte stream and assembles little-endian 32-bit words. Each word is written to ICCM through a simple write port, and one-cycle completion or error strobes go to the reset manager so the core is released only after a clean load.

## Interface
- ADDR_W, 12, ICCM word-address width; max image = 2**ADDR_W words
- TIMEOUT_CYC, 24'd2_000_000, idle cycles allowed between bytes while a frame is open
- clk_i  input  1  system clock
- rst_ni  input  1  reset; one clock; reset is synchronous and active-low
- rx_dv_i  input  1  byte-valid strobe, one cycle per byte, any spacing including back-to-back
- rx_byte_i  input  8  received byte, valid when rx_dv_i=1
- we_o  output  1  ICCM write strobe, one cycle per word
- addr_o  output  ADDR_W  ICCM word address
- wdata_o  output  32  ICCM write data
- busy_o  output  1  frame in progress (LEN_LO..CHK)
- done_o  output  1  one-cycle pulse: image loaded and verified
- err_o  output  1  sticky error flag
- err_code_o  output  2  0=none, 1=bad length, 2=timeout, 3=checksum

## Operation
- Frame: sync 0xA5, LEN[7:0], LEN[15:8], then LEN words of 4 bytes each, LSB first. With CHKSUM_EN, one checksum byte follows.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, ERR.
- IDLE: ignores every byte except 0xA5, which moves to LEN_LO. Accepting 0xA5 clears err_o, err_code_o, the word counter, the byte lane and the checksum accumulator.
- LEN_LO -> LEN_HI on the next byte.
- LEN_HI on its byte:
  - LEN==0 or LEN>2**ADDR_W -> ERR, code 1.
  - Otherwise -> DATA.
- DATA:
  - Byte lane 0..3 fills wdata bits [8k+7:8k].
  - On lane 3: we_o=1 the next cycle, with addr_o=word index (starting at 0) and wdata_o={b3,b2,b1,b0}. Word index increments after the write.
  - After word LEN-1: with CHKSUM_EN -> CHK; otherwise -> IDLE with done_o.
- CHK: the checksum byte arrives. Condition checked: (sum of LEN bytes + all payload bytes + checksum byte) mod 256 == 0.
  - Pass -> IDLE with done_o.
  - Fail -> ERR, code 3.
  - The words are already written to ICCM; only done_o is withheld.
- Timeout: in any state other than IDLE or ERR, TIMEOUT_CYC consecutive cycles without rx_dv_i -> ERR, code 2. The counter restarts on every rx_dv_i.
- ERR:
  - err_o=1 and busy_o=0.
  - Stays in ERR until a 0xA5 byte arrives, then -> LEN_LO and the error is cleared.
  - Other bytes are ignored.
- A 0xA5 byte inside DATA is payload, not a resync.
- Reset mid-frame: everything returns to reset values; partially assembled words are discarded and never written.

## Timing
- Reset values: we_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0, state IDLE.
- Write latency: we_o is asserted exactly 1 cycle after the rx_dv_i of the word's lane-3 byte. addr_o and wdata_o hold until the next write.
- done_o:
  - Without CHKSUM_EN: pulses in the cycle after the final we_o.
  - With CHKSUM_EN: pulses 1 cycle after the checksum byte's rx_dv_i.
- err_o: rises 1 cycle after the offending byte, or after the timeout expiry cycle.
- busy_o: rises 1 cycle after the sync byte; falls in the same cycle that done_o or err_o rises.
- Back-to-back rx_dv_i: a write strobe and the next lane-0 capture can coincide in the same cycle; both must take effect.
- Counters: word index has ADDR_W+1 bits, so that LEN=2**ADDR_W terminates correctly. The timeout counter saturates and never wraps.

## Configuration
- Macro: BOOT_LOADER_CHKSUM_EN.
- Defined: CHK state, 8-bit sum accumulator and error code 3 are present.
- Undefined: the frame ends after the last payload byte. No accumulator or CHK state is built, and error code 3 is never produced.

## Test plan
- Good frame, 2 words, CHKSUM_EN, bytes A5 02 00 13 00 00 00 6F 00 00 00 7C -> we_o twice:
  - addr 0 with data 0x00000013
  - addr 1 with data 0x0000006F
  - then one done_o pulse, err_o=0.
- Same frame with last byte 7D -> both writes occur, no done_o, err_o=1, err_code_o=3.
- Length cases:
  - A5 00 00 -> err_code_o=1.
  - A5 01 10 with ADDR_W=12 (LEN=0x1001) -> err_code_o=1.
  - Neither case produces any we_o.
- Stall after 5 payload bytes longer than TIMEOUT_CYC -> err_code_o=2, and only one write (addr 0) is observed. A following A5 clears err_o the next cycle.
- Leading garbage 00 FF 5A before a valid frame -> ignored; the frame then loads normally.
- Back-to-back rx_dv_i for a full frame -> correct writes and done_o.
- rst_ni low mid-DATA -> all outputs at reset values and no write of the partial word.

Source files
------------

// File: rtl/iccm_boot_loader_if.sv
// Byte-receiver input and ICCM write / status output bundle for iccm_boot_loader.
// slave = the loader, master = the byte source / memory / reset manager side.
interface iccm_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_dv_i;
    logic [7:0]        rx_byte_i;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [1:0]        err_code_o;

    modport slave (
        input  rx_dv_i, rx_byte_i,
        output we_o, addr_o, wdata_o,
        output busy_o, done_o, err_o, err_code_o
    );

    modport master (
        output rx_dv_i, rx_byte_i,
        input  we_o, addr_o, wdata_o,
        input  busy_o, done_o, err_o, err_code_o
    );
endinterface

// File: rtl/iccm_boot_loader.sv
// Framed boot-image loader: A5, LEN16, LEN little-endian words -> ICCM writes.
// Optional trailing checksum byte enabled by BOOT_LOADER_CHKSUM_EN.
module iccm_boot_loader #(
    parameter int          ADDR_W      = 12,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000
) (
    input logic clk_i,
    input logic rst_ni,
    iccm_boot_loader_if.slave bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE = 1;
    localparam logic [16:0] MAX_LEN = 17'(32'd1 << ADDR_W);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef BOOT_LOADER_CHKSUM_EN
        S_CHK,
`endif
        S_ERR
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   word_q;
    logic [CW-1:0]   len_q;
    logic [7:0]      len_lo_q;
    logic [1:0]      lane_q;
    logic [7:0]      b0_q, b1_q, b2_q;
    logic [23:0]     tmo_q;
    logic            done_pend_q;
    logic            we_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      code_q;
`ifdef BOOT_LOADER_CHKSUM_EN
    logic [7:0]      acc_q;
`endif

    logic [7:0]    rx_b;
    logic          rx_v;
    logic [15:0]   len_in;
    logic          len_bad;
    logic [CW-1:0] word_nxt;
    logic          active;
    logic          tmo_hit;

    assign rx_b     = bus.rx_byte_i;
    assign rx_v     = bus.rx_dv_i;
    assign len_in   = {rx_b, len_lo_q};
    assign len_bad  = (len_in == 16'd0) || ({1'b0, len_in} > MAX_LEN);
    assign word_nxt = word_q + ONE;
    assign active   = (state_q != S_IDLE) && (state_q != S_ERR);
    assign tmo_hit  = active && !rx_v && (tmo_q == TIMEOUT_CYC - 24'd1);

    assign bus.we_o       = we_q;
    assign bus.addr_o     = addr_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;

    // Frame FSM: parse bytes, assemble words, emit write/done/error strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            len_q       <= '0;
            len_lo_q    <= '0;
            lane_q      <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            tmo_q       <= '0;
            done_pend_q <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            code_q      <= 2'd0;
`ifdef BOOT_LOADER_CHKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;

            // The final write has just been strobed; finish the frame.
            if (done_pend_q) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end

            if (rx_v || !active) begin
                tmo_q <= '0;
            end else if (tmo_q != TIMEOUT_CYC) begin
                tmo_q <= tmo_q + 24'd1;
            end

            if (rx_v) begin
`ifdef BOOT_LOADER_CHKSUM_EN
                if (state_q == S_LEN_LO || state_q == S_LEN_HI ||
                    state_q == S_DATA) begin
                    acc_q <= acc_q + rx_b;
                end
`endif
                unique case (state_q)
                    S_IDLE, S_ERR: begin
                        if (rx_b == SYNC) begin
                            state_q <= S_LEN_LO;
                            err_q   <= 1'b0;
                            code_q  <= 2'd0;
                            word_q  <= '0;
                            lane_q  <= '0;
                            busy_q  <= 1'b1;
`ifdef BOOT_LOADER_CHKSUM_EN
                            acc_q   <= '0;
`endif
                        end
                    end
                    S_LEN_LO: begin
                        len_lo_q <= rx_b;
                        state_q  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if (len_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            code_q  <= 2'd1;
                            busy_q  <= 1'b0;
                        end else begin
                            len_q   <= len_in[CW-1:0];
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        lane_q <= lane_q + 2'd1;
                        unique case (lane_q)
                            2'd0: b0_q <= rx_b;
                            2'd1: b1_q <= rx_b;
                            2'd2: b2_q <= rx_b;
                            default: begin
                                we_q    <= 1'b1;
                                addr_q  <= word_q[ADDR_W-1:0];
                                wdata_q <= {rx_b, b2_q, b1_q, b0_q};
                                word_q  <= word_nxt;
                                if (word_nxt == len_q) begin
`ifdef BOOT_LOADER_CHKSUM_EN
                                    state_q <= S_CHK;
`else
                                    state_q     <= S_IDLE;
                                    done_pend_q <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
`ifdef BOOT_LOADER_CHKSUM_EN
                    S_CHK: begin
                        busy_q <= 1'b0;
                        if (acc_q + rx_b == 8'd0) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            code_q  <= 2'd3;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (tmo_hit) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                code_q  <= 2'd2;
                busy_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iccm_boot_loader.sv
// Scoreboard bench for iccm_boot_loader: expected writes queued per frame,
// popped by a write monitor; scenario tasks check status outputs inline.
module tb_iccm_boot_loader;
    localparam int ADDR_W = 12;
    localparam int TMO = 40;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    iccm_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    iccm_boot_loader #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(24'(TMO))
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int done_cnt = 0;
    logic [43:0] exp_q[$];
    logic [31:0] wq[$];
    logic [7:0] fq[$];

    // Write monitor: every we_o must match the next queued expectation.
    always @(negedge clk_i) begin
        if (bus.done_o) done_cnt++;
        if (bus.we_o) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h", bus.addr_o, bus.wdata_o);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({bus.addr_o, bus.wdata_o} !== e)
                    $display("FAIL write got=%h exp=%h", {bus.addr_o, bus.wdata_o}, e);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.rx_dv_i = 1'b0;
        bus.rx_byte_i = 8'h00;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_dv_i = 1'b1;
        bus.rx_byte_i = b;
        @(posedge clk_i);
        #1 bus.rx_dv_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Build frame bytes from wq and queue the expected writes.
    task automatic build_frame(input int len, input bit bad_chk);
        logic [7:0] s;
        logic [15:0] l;
        l = 16'(len);
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(l[7:0]);
        fq.push_back(l[15:8]);
        s = l[7:0] + l[15:8];
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = wq[i];
            exp_q.push_back({12'(i), w});
            for (int k = 0; k < 4; k++) begin
                fq.push_back(w[8*k +: 8]);
                s = s + w[8*k +: 8];
            end
        end
`ifdef BOOT_LOADER_CHKSUM_EN
        fq.push_back(8'h00 - s + {7'd0, bad_chk});
`else
        if (bad_chk) fq.push_back(8'h00);
`endif
    endtask

    // Drive fq; gap idle cycles between bytes (0 = back-to-back).
    task automatic send_frame(input int gap);
        for (int i = 0; i < fq.size(); i++) begin
            bus.rx_dv_i = 1'b1;
            bus.rx_byte_i = fq[i];
            @(posedge clk_i);
            #1;
            if (gap > 0 || i == fq.size() - 1) begin
                bus.rx_dv_i = 1'b0;
                if (gap > 0 && i != fq.size() - 1) idle(gap);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({bus.we_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {bus.we_o, bus.busy_o, bus.done_o, bus.err_o});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.addr_o, bus.wdata_o, bus.err_code_o} !== 46'd0) $display("FAIL reset_bus got=%h exp=0", {bus.addr_o, bus.wdata_o, bus.err_code_o});
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        int d0;
        do_reset();
        wq = '{32'h0000_0013, 32'h0000_006F};
        build_frame(2, 1'b0);
        d0 = done_cnt;
        send_byte(fq[0]);
        chk_cnt++;
        if (bus.busy_o !== 1'b1) $display("FAIL busy_rise got=%b exp=1", bus.busy_o);
        else pass_cnt++;
        fq.delete(0);
        idle(1);
        send_frame(1);
`ifdef BOOT_LOADER_CHKSUM_EN
        chk_cnt++;
        if ({bus.done_o, bus.busy_o} !== 2'b10) $display("FAIL done_chk_timing got=%b exp=10", {bus.done_o, bus.busy_o});
        else pass_cnt++;
`else
        chk_cnt++;
        if ({bus.we_o, bus.done_o} !== 2'b10) $display("FAIL last_write_timing got=%b exp=10", {bus.we_o, bus.done_o});
        else pass_cnt++;
        idle(1);
        chk_cnt++;
        if ({bus.we_o, bus.done_o, bus.busy_o} !== 3'b010) $display("FAIL done_timing got=%b exp=010", {bus.we_o, bus.done_o, bus.busy_o});
        else pass_cnt++;
`endif
        idle(4);
        chk_cnt++;
        if (done_cnt - d0 !== 1 || bus.err_o !== 1'b0) $display("FAIL good_done got=%0d err=%b exp=1 err=0", done_cnt - d0, bus.err_o);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL good_writes pending=%0d exp=0", exp_q.size());
        else pass_cnt++;
    endtask

`ifdef BOOT_LOADER_CHKSUM_EN
    task automatic test_checksum();
        int d0;
        do_reset();
        wq = '{32'h0000_0013, 32'h0000_006F};
        build_frame(2, 1'b1);
        chk_cnt++;
        if (fq[11] !== 8'h7D) $display("FAIL chk_byte got=%h exp=7d", fq[11]);
        else pass_cnt++;
        d0 = done_cnt;
        send_frame(0);
        idle(4);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o, bus.busy_o} !== 4'b1110 || done_cnt != d0) $display("FAIL bad_chk got=%b done=%0d exp=1110 done=0", {bus.err_o, bus.err_code_o, bus.busy_o}, done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL chk_writes pending=%0d exp=0", exp_q.size());
        else pass_cnt++;
    endtask
`endif

    task automatic test_bad_length();
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o, bus.busy_o} !== 4'b1010) $display("FAIL len_zero got=%b exp=1010", {bus.err_o, bus.err_code_o, bus.busy_o});
        else pass_cnt++;
        send_byte(8'hA5);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o} !== 3'b000) $display("FAIL err_clear got=%b exp=000", {bus.err_o, bus.err_code_o});
        else pass_cnt++;
        send_byte(8'h01);
        send_byte(8'h10);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o} !== 3'b101) $display("FAIL len_big got=%b exp=101", {bus.err_o, bus.err_code_o});
        else pass_cnt++;
        repeat (8) send_byte(8'h11);
        chk_cnt++;
        if ({bus.err_o, bus.busy_o, bus.we_o} !== 3'b100) $display("FAIL err_ignores got=%b exp=100", {bus.err_o, bus.busy_o, bus.we_o});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        exp_q.push_back({12'd0, 32'h4433_2211});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        idle(TMO - 5);
        chk_cnt++;
        if ({bus.err_o, bus.busy_o} !== 2'b01) $display("FAIL tmo_early got=%b exp=01", {bus.err_o, bus.busy_o});
        else pass_cnt++;
        idle(10);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o, bus.busy_o} !== 4'b1100) $display("FAIL tmo got=%b exp=1100", {bus.err_o, bus.err_code_o, bus.busy_o});
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() !== 0) $display("FAIL tmo_writes pending=%0d exp=0", exp_q.size());
        else pass_cnt++;
        send_byte(8'hA5);
        chk_cnt++;
        if ({bus.err_o, bus.err_code_o, bus.busy_o} !== 4'b0001) $display("FAIL tmo_clear got=%b exp=0001", {bus.err_o, bus.err_code_o, bus.busy_o});
        else pass_cnt++;
    endtask

    task automatic test_garbage();
        int d0;
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk_cnt++;
        if (bus.busy_o !== 1'b0) $display("FAIL garbage_busy got=%b exp=0", bus.busy_o);
        else pass_cnt++;
        wq = '{32'hDEAD_BEEF};
        build_frame(1, 1'b0);
        d0 = done_cnt;
        send_frame(2);
        idle(4);
        chk_cnt++;
        if (done_cnt - d0 !== 1 || bus.err_o !== 1'b0 || exp_q.size() !== 0) $display("FAIL garbage_frame done=%0d err=%b pend=%0d exp=1 0 0", done_cnt - d0, bus.err_o, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d0;
        do_reset();
        wq = '{32'hA5A5_A5A5, 32'h0102_03A5, 32'hCAFE_F00D};
        build_frame(3, 1'b0);
        d0 = done_cnt;
        send_frame(0);
        idle(4);
        chk_cnt++;
        if (done_cnt - d0 !== 1 || exp_q.size() !== 0) $display("FAIL b2b done=%0d pend=%0d exp=1 0", done_cnt - d0, exp_q.size());
        else pass_cnt++;
        wq.delete();
        for (int i = 0; i < 4096; i++)
            wq.push_back({8'hA5, 12'(i), 12'(i * 7)});
        build_frame(4096, 1'b0);
        d0 = done_cnt;
        send_frame(0);
        idle(4);
        chk_cnt++;
        if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || bus.err_o !== 1'b0) $display("FAIL max_len done=%0d pend=%0d err=%b exp=1 0 0", done_cnt - d0, exp_q.size(), bus.err_o);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        exp_q.push_back({12'd0, 32'h8765_4321});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h21);
        send_byte(8'h43);
        send_byte(8'h65);
        send_byte(8'h87);
        send_byte(8'h99);
        send_byte(8'h88);
        rst_ni = 1'b0;
        idle(1);
        chk_cnt++;
        if ({bus.we_o, bus.busy_o, bus.done_o, bus.err_o, bus.addr_o, bus.wdata_o} !== 48'd0) $display("FAIL mid_reset got=%h exp=0", {bus.we_o, bus.busy_o, bus.done_o, bus.err_o, bus.addr_o, bus.wdata_o});
        else pass_cnt++;
        rst_ni = 1'b1;
        send_byte(8'h77);
        send_byte(8'h66);
        idle(6);
        chk_cnt++;
        if (bus.busy_o !== 1'b0 || exp_q.size() !== 0) $display("FAIL mid_reset_after busy=%b pend=%0d exp=0 0", bus.busy_o, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        bus.rx_dv_i = 1'b0;
        bus.rx_byte_i = 8'h00;
        test_reset();
        test_good_frame();
`ifdef BOOT_LOADER_CHKSUM_EN
        test_checksum();
`endif
        test_bad_length();
        test_timeout();
        test_garbage();
        test_back_to_back();
        test_mid_reset();
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
